// File: rtl/kernel_bram_loader.sv
// Packs a 16-bit weight stream into 144-bit 3x3 kernel words and writes one word per
// channel into kernel BRAM port A, reporting busy/done/err to the layer controller.
//
// state   | meaning
// IDLE    | waiting for start, stream not accepted
// LOAD    | accepting weights into the pack register
// WRITE   | one-cycle BRAM write of the packed word
// DONE    | one-cycle completion pulse
module kernel_bram_loader #(
    parameter int KERNEL_WIDTH = 16,
    parameter int KERNEL_SIZE  = 9,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [ADDR_WIDTH:0]                num_channels,
    input  logic [KERNEL_WIDTH-1:0]            s_axis_tdata,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    output logic                               ena_kernel_BRAM,
    output logic                               wea_kernel_BRAM,
    output logic [ADDR_WIDTH-1:0]              kernel_BRAM_addra,
    output logic [KERNEL_WIDTH*KERNEL_SIZE-1:0] kernel_BRAM_dina,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int BEAT_W = $clog2(KERNEL_SIZE);
    localparam int WORD_W = KERNEL_WIDTH * KERNEL_SIZE;
    localparam logic [CNT_W-1:0]  MAX_CH    = CNT_W'(1) << ADDR_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    chan_q, chan_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic                err_q, err_d;
    logic                wr_q, wr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CNT_W-1:0]    num_clamped;
    logic                accept;
    logic                last_chan;
    logic                last_beat;

    assign num_clamped = (num_channels > MAX_CH) ? MAX_CH : num_channels;
    assign accept      = (state_q == S_LOAD) && s_axis_tvalid;
    assign last_chan   = (chan_q == num_q - CNT_W'(1));
    assign last_beat   = (beat_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        chan_d  = chan_q;
        beat_d  = beat_q;
        pack_d  = pack_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_clamped;
                    chan_d  = '0;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = (num_clamped == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    for (int k = 0; k < KERNEL_SIZE; k++) begin
                        if (beat_q == BEAT_W'(k)) pack_d[k*KERNEL_WIDTH +: KERNEL_WIDTH] = s_axis_tdata;
                    end
                    beat_d = beat_q + BEAT_W'(1);
                    // tlast anywhere but the final beat of the final channel aborts the set
                    if (s_axis_tlast && !(last_chan && last_beat)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (last_beat) begin
                        if (last_chan && !s_axis_tlast) err_d = 1'b1;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                chan_d  = chan_q + CNT_W'(1);
                beat_d  = '0;
                state_d = last_chan ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        wr_d   = (state_d == S_WRITE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            chan_q  <= '0;
            beat_q  <= '0;
            pack_q  <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            chan_q  <= chan_d;
            beat_q  <= beat_d;
            pack_q  <= pack_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s_axis_tready     = (state_q == S_LOAD);
    assign ena_kernel_BRAM   = wr_q;
    assign wea_kernel_BRAM   = wr_q;
    assign kernel_BRAM_addra = chan_q[ADDR_WIDTH-1:0];
    assign kernel_BRAM_dina  = pack_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;

endmodule

// File: doc/kernel_bram_loader.md
Name: kernel_bram_loader

Overview:
Upstream loader for the 3x3 kernel BRAM. It accepts a 16-bit AXI-Stream of kernel weights from the host/DMA and packs each group of 9 consecutive weights into one 144-bit word. It writes that word into the kernel BRAM write port (port A) at address = channel index, for a programmed number of channels. It reports busy, done and error status to the layer controller.

Parameters:
KERNEL_WIDTH, 16, bit width of one kernel weight
KERNEL_SIZE, 9, weights per channel word (3x3)
ADDR_WIDTH, 8, kernel BRAM address width (256 channels max)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load when idle
num_channels  input  ADDR_WIDTH+1  channels to load, 0..256; sampled on accepted start
s_axis_tdata  input  KERNEL_WIDTH  weight value
s_axis_tvalid  input  1  weight valid
s_axis_tready  output  1  loader ready for a weight
s_axis_tlast  input  1  marks the final weight of the whole kernel set
ena_kernel_BRAM  output  1  BRAM port A enable
wea_kernel_BRAM  output  1  BRAM port A write enable
kernel_BRAM_addra  output  ADDR_WIDTH  BRAM port A address
kernel_BRAM_dina  output  KERNEL_WIDTH*KERNEL_SIZE  packed 144-bit kernel word
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse
err  output  1  sticky tlast-mismatch flag; cleared on next accepted start

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Counters, the partial pack register and err are cleared. Reset mid-load discards the partial word and issues no write.
- FSM states:
  - IDLE: tready=0. On start, latch num_channels, clear channel_cnt/beat_cnt/err, set busy. Go to LOAD; if num_channels==0, go to DONE instead.
  - LOAD: tready=1. A beat is accepted when tvalid&&tready.
    - Beat k (0..8) is stored at dina bits [16k+15:16k], so the first weight lands in the LSBs.
    - beat_cnt increments per accepted beat. On the 9th beat, go to WRITE.
  - WRITE: exactly one cycle. tready=0. ena=wea=1, addra=channel_cnt, dina=packed word.
    - Next cycle, ena/wea return to 0 and channel_cnt increments.
    - If channel_cnt==num_channels-1, go to DONE; else return to LOAD with beat_cnt=0.
  - DONE: one cycle. done=1, busy=0 from the next cycle, then return to IDLE.
- Outputs ena, wea, addra and dina are registered. The BRAM sees the write on the clock edge that ends the WRITE cycle.
- Throughput: 10 cycles per channel with a continuous stream (9 accept cycles + 1 write cycle). Total = 10*N + 1 (DONE) cycles after the start cycle.
- tvalid low in LOAD stalls; no state change and no data loss. tdata is ignored when not accepted.
- tlast rules:
  - Expected only on beat 8 of the last channel.
  - tlast on any earlier accepted beat: set err, drop the partial word (no write), go to DONE.
  - Last beat accepted without tlast: set err, but still write the word and finish normally.
- start while busy: ignored. num_channels changes while busy: ignored (latched value used).
- Address wrap: impossible, since num_channels<=256 and the last write address is 255. num_channels>256 is clamped to 256.
- Port B of the BRAM is untouched; the consumer must not read until done.

Test Plan:
- Reset, start with num_channels=1, stream weights 1..9 with tlast on the 9th -> one write at addra=0, dina=0x0009_0008_..._0001 (weight 1 in [15:0]); done pulses at cycle 11 after start; err=0.
- num_channels=3, continuous stream 27 beats, tlast on beat 27 -> writes at addra 0,1,2 on cycles 10,20,30; tready low on each write cycle; done after the 3rd write.
- Same as above but tvalid toggled 1/0 every cycle -> identical written words and addresses; completion delayed accordingly; no lost beats.
- num_channels=2, tlast asserted on beat 5 -> err=1; no write for channel 0; done pulses; busy falls; next start clears err.
- num_channels=0 start -> done pulse the next cycle; no wea; start pulse during busy -> ignored (write count unchanged).
- Assert rst_n low after 4 accepted beats of channel 0 -> all outputs 0 immediately; no write; fresh start then loads correctly from addra=0.
